// File: rtl/instruction_loader_pkg.sv
// Shared constants, FSM state encoding and the COUNT legality helper for the
// instruction loader. Optional CHK byte: define INSTRUCTION_LOADER_CHECKSUM_EN.
package instruction_loader_pkg;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         BYTES_PER_INSTR = 4;
  localparam int         INSTR_W         = 28;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  // A frame must carry between 1 and depth words.
  function automatic logic count_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Handshake: a byte transfers on a rising clock when iByteValid && oByteReady.
interface instruction_loader_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = instruction_loader_pkg::INSTR_W
);
  logic [7:0]         iByte;
  logic               iByteValid;
  logic               oByteReady;
  logic               oWriteEnable;
  logic [ADDR_W-1:0]  oWriteAddress;
  logic [INSTR_W-1:0] oWriteData;
  logic               oCpuReset;
  logic               oDone;
  logic               oError;

  modport master (
    output iByte, iByteValid,
    input  oByteReady, oWriteEnable, oWriteAddress, oWriteData,
    input  oCpuReset, oDone, oError
  );

  modport slave (
    input  iByte, iByteValid,
    output oByteReady, oWriteEnable, oWriteAddress, oWriteData,
    output oCpuReset, oDone, oError
  );
endinterface

// File: rtl/instruction_loader_packer.sv
// Packs four big-endian stream bytes into one 28-bit instruction word; only the
// low nibble of the first byte survives.
module instr_word_packer
  import instruction_loader_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic               word_ready_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [1:0]  idx_q;
  logic [19:0] sr_q;

  // After three shifts sr_q holds {byte0[3:0], byte1, byte2}; byte0[7:4] falls off the top.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idx_q <= 2'd0;
      sr_q  <= '0;
    end else if (clear_i) begin
      idx_q <= 2'd0;
    end else if (shift_i) begin
      idx_q <= idx_q + 2'd1;
      sr_q  <= {sr_q[11:0], byte_i};
    end
  end

  assign word_ready_o = shift_i && (idx_q == 2'(BYTES_PER_INSTR - 1));
  assign word_o       = {sr_q, byte_i};

endmodule

// File: rtl/instruction_loader.sv
// Frame receiver that writes packed instruction words into the instruction RAM
// and holds the core in reset until a load completes. Option: INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  instruction_loader_if.slave  bus,
  output state_t               dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t             state_q;
  logic               ready_q, we_q, cpu_rst_q, done_q, err_q;
  logic [ADDR_W-1:0]  addr_q, widx_q, last_q;
  logic [INSTR_W-1:0] data_q;
  logic               accept, word_ready;
  logic [INSTR_W-1:0] word;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]         acc_q;
`endif

  assign accept = bus.iByteValid && ready_q;

  instr_word_packer u_packer (
    .Clock        (Clock),
    .Reset        (Reset),
    .clear_i      (accept && (state_q == S_COUNT)),
    .shift_i      (accept && (state_q == S_DATA)),
    .byte_i       (bus.iByte),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      widx_q    <= '0;
      last_q    <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && bus.iByte == SYNC_BYTE) begin
            state_q <= S_COUNT;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (!count_ok(bus.iByte, DEPTH)) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              // Store N-1 so a full 2^ADDR_W frame still fits in ADDR_W bits.
              last_q  <= ADDR_W'(bus.iByte - 8'd1);
              widx_q  <= '0;
              state_q <= S_DATA;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
              acc_q   <= acc_q ^ bus.iByte;
`endif
            end
          end
        end
        S_DATA: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          if (accept) acc_q <= acc_q ^ bus.iByte;
`endif
          if (word_ready) begin
            we_q   <= 1'b1;
            addr_q <= widx_q;
            data_q <= word;
            widx_q <= widx_q + 1'b1;
            if (widx_q == last_q) state_q <= S_CHK;
          end
        end
        S_CHK: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          if (accept) begin
            if (bus.iByte == acc_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
`else
          // Without a CHK byte this state only lets the last write strobe retire.
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          cpu_rst_q <= 1'b0;
`endif
        end
        S_DONE, S_ERROR: begin
          if (accept && bus.iByte == SYNC_BYTE) begin
            state_q   <= S_COUNT;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            widx_q    <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            acc_q     <= '0;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.oByteReady    = ready_q;
  assign bus.oWriteEnable  = we_q;
  assign bus.oWriteAddress = addr_q;
  assign bus.oWriteData    = data_q;
  assign bus.oCpuReset     = cpu_rst_q;
  assign bus.oDone         = done_q;
  assign bus.oError        = err_q;
  assign dbg_state_o       = state_q;

endmodule
